// File: rtl/imem_loader.sv
// Instruction-memory program loader: receives a framed byte stream (length, N data bytes, checksum),
// writes the data bytes to sequential addresses, and holds the core until a good frame has loaded.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t r_state;
    state_t w_state_next;

    logic [8:0]        r_remain;
    logic [7:0]        r_acc;
    logic [ADDR_W-1:0] r_addr_ctr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_word_count;
    logic              r_wr_en;
    logic              r_in_ready;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_hold;

    logic              w_xfer;
    logic              w_wr_fire;
    logic              w_last_data;
    logic [7:0]        w_chk_sum;
    logic [8:0]        w_frame_len;

    assign w_xfer      = in_valid & r_in_ready;
    assign w_wr_fire   = w_xfer & (r_state == S_DATA) & ~start;
    assign w_last_data = (r_remain == 9'd1);
    assign w_chk_sum   = r_acc + in_data;
    // A length byte of zero encodes a full 256-word frame.
    assign w_frame_len = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_LEN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_LEN: begin
                    if (w_xfer) w_state_next = S_DATA;
                end
                S_DATA: begin
                    if (w_xfer && w_last_data) w_state_next = S_CHK;
                end
                S_CHK: begin
                    if (w_xfer) w_state_next = (w_chk_sum == 8'd0) ? S_DONE : S_ERROR;
                end
                S_DONE:  w_state_next = S_DONE;
                S_ERROR: w_state_next = S_ERROR;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_wr_en    <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == S_LEN) || (w_state_next == S_DATA) ||
                          (w_state_next == S_CHK);
            r_done     <= (w_state_next == S_DONE);
            r_error    <= (w_state_next == S_ERROR);
            r_cpu_hold <= (w_state_next != S_DONE);
            r_wr_en    <= w_wr_fire;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_remain     <= 9'd0;
            r_acc        <= 8'd0;
            r_addr_ctr   <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
        end else if (start) begin
            // A restart discards any byte accepted in this cycle along with its write.
            r_remain     <= 9'd0;
            r_acc        <= 8'd0;
            r_addr_ctr   <= '0;
            r_wr_addr    <= '0;
            r_word_count <= '0;
        end else begin
            if (w_xfer && (r_state == S_LEN)) begin
                r_remain <= w_frame_len;
                r_acc    <= 8'd0;
            end
            if (w_wr_fire) begin
                r_remain   <= r_remain - 9'd1;
                r_acc      <= w_chk_sum;
                r_wr_addr  <= r_addr_ctr;
                r_wr_data  <= DATA_W'(in_data);
                r_addr_ctr <= r_addr_ctr + ADDR_ONE;
                if (r_word_count != ADDR_MAX) begin
                    r_word_count <= r_word_count + ADDR_ONE;
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, bad checksum, full 256-word frame, stalls,
// mid-frame restart and mid-frame reset, with writes captured by a negedge monitor.
module tb_imem_loader;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [7:0] word_count;

    int checks;
    int failures;

    logic [7:0] log_addr [0:1023];
    logic [7:0] log_data [0:1023];
    int         log_cyc  [0:1023];
    int         wn;
    int         cyc;

    imem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        wn  = 0;
        cyc = 0;
    end

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (wr_en === 1'b1) begin
            log_addr[wn] <= wr_addr;
            log_data[wn] <= wr_data;
            log_cyc[wn]  <= cyc;
            wn           <= wn + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            chk("gap_no_wr_en", {31'd0, wr_en}, 32'd0);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("in_ready_timeout", {31'd0, (guard < 50)}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},   {31'd0, in_ready}, 32'd0);
        chk({tag, "_wr_en"},      {31'd0, wr_en},    32'd0);
        chk({tag, "_wr_addr"},    {24'd0, wr_addr},  32'd0);
        chk({tag, "_wr_data"},    {24'd0, wr_data},  32'd0);
        chk({tag, "_cpu_hold"},   {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_done"},       {31'd0, done},     32'd0);
        chk({tag, "_error"},      {31'd0, error},    32'd0);
        chk({tag, "_word_count"}, {24'd0, word_count}, 32'd0);
    endtask

    task automatic check_abc_writes(input string tag, input int base);
        chk({tag, "_nwrites"}, wn - base, 32'd3);
        chk({tag, "_a0"}, {24'd0, log_addr[base]},   32'h00);
        chk({tag, "_d0"}, {24'd0, log_data[base]},   32'h21);
        chk({tag, "_a1"}, {24'd0, log_addr[base+1]}, 32'h01);
        chk({tag, "_d1"}, {24'd0, log_data[base+1]}, 32'h4A);
        chk({tag, "_a2"}, {24'd0, log_addr[base+2]}, 32'h02);
        chk({tag, "_d2"}, {24'd0, log_data[base+2]}, 32'hE3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int base2;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clock);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Good frame, continuous valid
        pulse_start();
        chk("len_in_ready", {31'd0, in_ready}, 32'd1);
        base = wn;
        send(8'd3);
        send(8'h21);
        chk("s1_first_wr_en",   {31'd0, wr_en},   32'd1);
        chk("s1_first_wr_addr", {24'd0, wr_addr}, 32'h00);
        chk("s1_first_wr_data", {24'd0, wr_data}, 32'h21);
        send(8'h4A);
        send(8'hE3);
        chk("s1_done_before_chk", {31'd0, done}, 32'd0);
        send(8'hB2);
        chk("s1_done",       {31'd0, done},       32'd1);
        chk("s1_cpu_hold",   {31'd0, cpu_hold},   32'd0);
        chk("s1_error",      {31'd0, error},      32'd0);
        chk("s1_word_count", {24'd0, word_count}, 32'd3);
        chk("s1_in_ready",   {31'd0, in_ready},   32'd0);
        check_abc_writes("s1", base);
        chk("s1_consec01", log_cyc[base+1] - log_cyc[base],   32'd1);
        chk("s1_consec12", log_cyc[base+2] - log_cyc[base+1], 32'd1);

        // Restart from DONE, bad checksum
        pulse_start();
        chk("s2_done_cleared", {31'd0, done},       32'd0);
        chk("s2_hold_set",     {31'd0, cpu_hold},   32'd1);
        chk("s2_in_ready",     {31'd0, in_ready},   32'd1);
        chk("s2_wc_cleared",   {24'd0, word_count}, 32'd0);
        base = wn;
        send(8'd3);
        send(8'h21);
        send(8'h4A);
        send(8'hE3);
        send(8'hB3);
        chk("s2_error",      {31'd0, error},      32'd1);
        chk("s2_done",       {31'd0, done},       32'd0);
        chk("s2_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        chk("s2_word_count", {24'd0, word_count}, 32'd3);
        check_abc_writes("s2", base);
        pulse_start();
        chk("s2_error_cleared", {31'd0, error},    32'd0);
        chk("s2_ready_again",   {31'd0, in_ready}, 32'd1);

        // Full 256-word frame (length byte 0), data = address
        base = wn;
        send(8'd0);
        for (int i = 0; i < 256; i++) send(8'(i));
        chk("s3_done_before_chk", {31'd0, done}, 32'd0);
        send(8'h80);
        chk("s3_done",       {31'd0, done},       32'd1);
        chk("s3_word_count", {24'd0, word_count}, 32'd255);
        chk("s3_nwrites",    wn - base,           32'd256);
        for (int i = 0; i < 256; i++) begin
            chk("s3_addr", {24'd0, log_addr[base+i]}, i);
            chk("s3_data", {24'd0, log_data[base+i]}, i);
        end

        // Good frame with valid gaps 1,0,0,1,0,1
        pulse_start();
        base = wn;
        send(8'd3);
        send(8'h21);
        idle(2);
        send(8'h4A);
        idle(1);
        send(8'hE3);
        idle(1);
        chk("s4_no_done_yet", {31'd0, done}, 32'd0);
        send(8'hB2);
        chk("s4_done",       {31'd0, done},       32'd1);
        chk("s4_word_count", {24'd0, word_count}, 32'd3);
        check_abc_writes("s4", base);

        // Restart after the 2nd data byte, then a one-word frame
        pulse_start();
        base = wn;
        send(8'd4);
        send(8'h11);
        send(8'h22);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(negedge clock);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("s5_dropped_wr_en", {31'd0, wr_en},      32'd0);
        chk("s5_abort_ready",   {31'd0, in_ready},   32'd1);
        chk("s5_abort_wc",      {24'd0, word_count}, 32'd0);
        chk("s5_abort_addr",    {24'd0, wr_addr},    32'd0);
        chk("s5_pre_writes",    wn - base,           32'd2);
        base2 = wn;
        send(8'd1);
        send(8'h5C);
        send(8'hA4);
        chk("s5_done",       {31'd0, done},       32'd1);
        chk("s5_word_count", {24'd0, word_count}, 32'd1);
        chk("s5_nwrites",    wn - base2,          32'd1);
        chk("s5_a0", {24'd0, log_addr[base2]}, 32'h00);
        chk("s5_d0", {24'd0, log_data[base2]}, 32'h5C);

        // Reset during DATA after one write, then a clean frame
        pulse_start();
        send(8'd3);
        send(8'h21);
        chk("s6_wr_before_rst", {31'd0, wr_en}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("s6_rst");
        reset = 1'b0;
        @(negedge clock);
        chk("s6_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("s6_idle_hold",  {31'd0, cpu_hold}, 32'd1);
        pulse_start();
        base = wn;
        send(8'd3);
        send(8'h21);
        send(8'h4A);
        send(8'hE3);
        send(8'hB2);
        chk("s6_done",       {31'd0, done},       32'd1);
        chk("s6_word_count", {24'd0, word_count}, 32'd3);
        check_abc_writes("s6", base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
